// File: rtl/ov7670_pkg.sv
// Shared types and default frame dimensions for the OV7670 capture path and
// the ILI9341 driver.
package ov7670_pkg;

  localparam int unsigned OV_H_PIXELS = 320;
  localparam int unsigned OV_V_LINES  = 240;
  localparam int unsigned OV_X_W      = 9;
  localparam int unsigned OV_Y_W      = 8;
  localparam int unsigned OV_DATA_W   = 8;

  typedef logic [15:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    VBLANK,
    LINE_WAIT,
    HI_BYTE,
    LO_BYTE
  } capture_state_t;

endpackage

// File: rtl/ov7670_pixel_capture_sync_edge_detect.sv
// Multi-flop synchronizer with registered edge strobes on the low EDGE_WIDTH bits.
// The low EDGE_ONLY bits are strobe-only; their synced level is not exported.
module sync_edge_detect #(
  parameter int unsigned           WIDTH       = 1,
  parameter int unsigned           EDGE_WIDTH  = 1,
  parameter int unsigned           EDGE_ONLY   = 0,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [EDGE_WIDTH-1:0] FALL_MASK   = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           raw,
  output logic [WIDTH-1:EDGE_ONLY]   sync,
  output logic [EDGE_WIDTH-1:0]      strobe
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] last;

  assign last = chain[SYNC_STAGES-1];
  assign sync = prev[WIDTH-1:EDGE_ONLY];

  // Levels and strobes leave through one extra flop so both stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev   <= '0;
      strobe <= '0;
    end else begin
      chain[0] <= raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev   <= last;
      strobe <= (last[EDGE_WIDTH-1:0] ^ prev[EDGE_WIDTH-1:0]) &
                (last[EDGE_WIDTH-1:0] ^ FALL_MASK);
    end
  end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 byte-stream capture: oversamples the camera bus, pairs bytes into
// RGB565 pixels with x/y tags, and reports frame boundaries and errors.
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned H_PIXELS    = OV_H_PIXELS,
  parameter int unsigned V_LINES     = OV_V_LINES,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 href,
  input  logic                 pclk,
  input  logic [OV_DATA_W-1:0] camData,
  output logic                 pixelValid,
  output pixel_t               pixelData,
  output logic [OV_X_W-1:0]    pixelX,
  output logic [OV_Y_W-1:0]    pixelY,
  output logic                 frameStart,
  output logic                 frameDone,
  output logic                 lineError,
  output logic                 overrun
);

  localparam int unsigned RAW_W = OV_DATA_W + 3;
  localparam logic [OV_X_W-1:0] X_MAX = OV_X_W'(H_PIXELS);
  localparam logic [OV_Y_W-1:0] Y_MAX = OV_Y_W'(V_LINES);

  logic [RAW_W-1:1]     sync_lvl;
  logic [2:0]           strobe;
  logic                 href_s, vsync_s;
  logic [OV_DATA_W-1:0] data_s;
  logic                 pclk_edge, href_fall, vsync_rise;

  // Bit 0 pclk (rise), bit 1 href (fall), bit 2 vsync (rise), then data.
  sync_edge_detect #(
    .WIDTH       (RAW_W),
    .EDGE_WIDTH  (3),
    .EDGE_ONLY   (1),
    .SYNC_STAGES (SYNC_STAGES),
    .FALL_MASK   (3'b010)
  ) u_sync (
    .clk    (clk),
    .rst_n  (reset),
    .raw    ({camData, vsync, href, pclk}),
    .sync   (sync_lvl),
    .strobe (strobe)
  );

  assign href_s     = sync_lvl[1];
  assign vsync_s    = sync_lvl[2];
  assign data_s     = sync_lvl[RAW_W-1:3];
  assign pclk_edge  = strobe[0];
  assign href_fall  = strobe[1];
  assign vsync_rise = strobe[2];

  capture_state_t       state_q, state_d;
  logic [OV_X_W-1:0]    x_q, x_d;
  logic [OV_Y_W-1:0]    y_q, y_d;
  logic [OV_DATA_W-1:0] hi_q, hi_d;
  logic                 valid_d, start_d, done_d, lerr_d, ovr_d;
  pixel_t               data_d;
  logic [OV_X_W-1:0]    px_d;
  logic [OV_Y_W-1:0]    py_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      hi_q       <= '0;
      pixelValid <= 1'b0;
      pixelData  <= '0;
      pixelX     <= '0;
      pixelY     <= '0;
      frameStart <= 1'b0;
      frameDone  <= 1'b0;
      lineError  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hi_q       <= hi_d;
      pixelValid <= valid_d;
      pixelData  <= data_d;
      pixelX     <= px_d;
      pixelY     <= py_d;
      frameStart <= start_d;
      frameDone  <= done_d;
      lineError  <= lerr_d;
      overrun    <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    hi_d    = hi_q;
    valid_d = 1'b0;
    data_d  = pixelData;
    px_d    = pixelX;
    py_d    = pixelY;
    start_d = 1'b0;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
    ovr_d   = overrun;

    if (vsync_rise) begin
      // A new frame always wins, even over a half-received pixel.
      state_d = VBLANK;
      start_d = 1'b1;
      ovr_d   = 1'b0;
      done_d  = (state_q != IDLE) &&
                ((y_q != '0) || (state_q == HI_BYTE) || (state_q == LO_BYTE));
      x_d     = '0;
      y_d     = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        VBLANK: begin
          x_d = '0;
          y_d = '0;
          if (!vsync_s) state_d = LINE_WAIT;
        end
        LINE_WAIT, HI_BYTE: begin
          if (href_fall && state_q == HI_BYTE) begin
            state_d = LINE_WAIT;
            x_d     = '0;
            if (x_q != '0) y_d = y_q + OV_Y_W'(1);
          end else if (pclk_edge && href_s) begin
            hi_d    = data_s;
            state_d = LO_BYTE;
          end
        end
        LO_BYTE: begin
          if (href_fall) begin
            state_d = LINE_WAIT;
            lerr_d  = 1'b1;
            x_d     = '0;
            if (x_q != '0) y_d = y_q + OV_Y_W'(1);
          end else if (pclk_edge && href_s) begin
            state_d = HI_BYTE;
            if (x_q < X_MAX && y_q < Y_MAX) begin
              valid_d = 1'b1;
              data_d  = {hi_q, data_s};
              px_d    = x_q;
              py_d    = y_q;
              x_d     = x_q + OV_X_W'(1);
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
